interrupt_sequencer: RTL and testbench

- 6502-core block that decides when the CPU leaves normal execution for NMI, IRQ, BRK or the power-on/reset entry.
- Runs the 7-cycle entry sequence: dummy reads, PCH/PCL/P pushes, vector fetch, PC load.
- Consumes the P register value (I flag, pushed byte) and feeds P register write-enable/data to set I on entry.
- Sits beside the instruction decoder and drives the address/data bus, stack-pointer decrement and PC load while busy.

---
 rtl/interrupt_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_interrupt_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// interrupt_sequencer
//
// Decides when a 6502-style CPU leaves normal execution for NMI, IRQ, BRK or
// the power-on/reset entry, and runs the seven-step entry sequence:
//   T0, T1 : dummy reads at the current PC
//   T2..T4 : push PCH, PCL, P onto the stack page (reads only for RESET)
//   T5     : fetch vector low byte, set the I flag in P
//   T6     : fetch vector high byte, load PC
//
// Handshake: there is no valid/ready pair here. The decoder raises poll on
// the last cycle of an instruction; busy=1 tells it to hold off until the
// sequence returns to IDLE. Every state step and every strobe is qualified by
// cpu_en; a cpu_en=0 cycle is a pure stall.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   cpu_en          clock enable for all sequencer state
//   nmi_n, irq_n    NMI (falling-edge) and IRQ (level) request lines
//   poll, brk       decoder strobe (last instruction cycle) and BRK request
//   p_in, pc_in     current P register and PC
//   s_in            current stack pointer
//   rd_data         memory read data for the current addr
//   busy            sequence in progress
//   addr, wdata, we bus address, write data, write strobe
//   s_dec           decrement S this cycle
//   pc_load,pc_next load PC with pc_next this cycle
//   p_write, p_wd0  per-bit write enable / data toward P
//   dbg_state       current sequencer state, for observation only
// -----------------------------------------------------------------------------
module interrupt_sequencer #(
  parameter logic [15:0] NMI_VEC    = 16'hFFFA,
  parameter logic [15:0] RST_VEC    = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC    = 16'hFFFE,
  parameter logic [7:0]  STACK_PAGE = 8'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_en,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        poll,
  input  logic        brk,
  input  logic [7:0]  p_in,
  input  logic [15:0] pc_in,
  input  logic [7:0]  s_in,
  input  logic [7:0]  rd_data,
  output logic        busy,
  output logic [15:0] addr,
  output logic [7:0]  wdata,
  output logic        we,
  output logic        s_dec,
  output logic        pc_load,
  output logic [15:0] pc_next,
  output logic [7:0]  p_write,
  output logic [7:0]  p_wd0,
  output logic [2:0]  dbg_state
);

  // Sequencer states
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T0   = 3'd1;
  localparam logic [2:0] S_T1   = 3'd2;
  localparam logic [2:0] S_T2   = 3'd3;
  localparam logic [2:0] S_T3   = 3'd4;
  localparam logic [2:0] S_T4   = 3'd5;
  localparam logic [2:0] S_T5   = 3'd6;
  localparam logic [2:0] S_T6   = 3'd7;

  // Kind of entry being serviced
  localparam logic [1:0] K_RESET = 2'd0;
  localparam logic [1:0] K_NMI   = 2'd1;
  localparam logic [1:0] K_IRQ   = 2'd2;
  localparam logic [1:0] K_BRK   = 2'd3;

  // I flag position in P
  localparam logic [7:0] P_I_MASK = 8'h04;

  logic [2:0]  state_q, state_d;
  logic [1:0]  kind_q, kind_d;
  logic        nmi_pending_q, nmi_pending_d;
  logic        nmi_prev_q, nmi_prev_d;
  logic [15:0] vec_q, vec_d;
  logic [7:0]  lo_q, lo_d;

  logic        nmi_edge;
  logic        nmi_clr;
  logic        strobe_ok;
  logic        we_raw, s_dec_raw, pc_load_raw, p_write_raw;
  logic [15:0] stack_addr;
  logic [7:0]  p_push;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    vec_d         = vec_q;
    lo_d          = lo_q;
    nmi_prev_d    = nmi_prev_q;
    nmi_pending_d = nmi_pending_q;
    nmi_edge      = nmi_prev_q & ~nmi_n;
    nmi_clr       = 1'b0;

    if (cpu_en) begin
      case (state_q)
        S_IDLE: begin
          if (poll) begin
            // Priority: pending NMI, unmasked IRQ, then BRK. An IRQ taken
            // in the same poll as a BRK simply drops the BRK.
            if (nmi_pending_q) begin
              kind_d  = K_NMI;
              state_d = S_T0;
            end else if (!irq_n && !p_in[2]) begin
              kind_d  = K_IRQ;
              state_d = S_T0;
            end else if (brk) begin
              kind_d  = K_BRK;
              state_d = S_T0;
            end
          end
        end
        S_T0: state_d = S_T1;
        S_T1: state_d = S_T2;
        S_T2: state_d = S_T3;
        S_T3: state_d = S_T4;
        S_T4: begin
          state_d = S_T5;
          // The vector is chosen as late as possible so an NMI arriving
          // during an IRQ/BRK push hijacks the entry (B already pushed).
          if (kind_q == K_RESET) begin
            vec_d = RST_VEC;
          end else if (nmi_pending_q) begin
            vec_d   = NMI_VEC;
            nmi_clr = 1'b1;
          end else if (kind_q == K_NMI) begin
            vec_d = NMI_VEC;
          end else begin
            vec_d = IRQ_VEC;
          end
        end
        S_T5: begin
          lo_d    = rd_data;
          state_d = S_T6;
        end
        S_T6: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase

      // A fresh falling edge survives a simultaneous clear so it is taken
      // at the next poll rather than lost.
      nmi_prev_d    = nmi_n;
      nmi_pending_d = (nmi_pending_q & ~nmi_clr) | nmi_edge;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_T0;
      kind_q        <= K_RESET;
      nmi_pending_q <= 1'b0;
      nmi_prev_q    <= 1'b1;
      vec_q         <= RST_VEC;
      lo_q          <= 8'h00;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      nmi_pending_q <= nmi_pending_d;
      nmi_prev_q    <= nmi_prev_d;
      vec_q         <= vec_d;
      lo_q          <= lo_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus and register-file outputs
  // ---------------------------------------------------------------------------
  assign stack_addr = {STACK_PAGE, s_in};
  // Pushed P: bit 5 always reads 1, bit 4 (B) marks a software BRK.
  assign p_push     = {p_in[7:6], 1'b1, (kind_q == K_BRK), p_in[3:0]};

  always_comb begin
    addr        = pc_in;
    wdata       = 8'h00;
    we_raw      = 1'b0;
    s_dec_raw   = 1'b0;
    pc_load_raw = 1'b0;
    p_write_raw = 1'b0;

    case (state_q)
      S_T0, S_T1: addr = pc_in;
      S_T2: begin
        addr      = stack_addr;
        wdata     = pc_in[15:8];
        we_raw    = (kind_q != K_RESET);
        s_dec_raw = 1'b1;
      end
      S_T3: begin
        addr      = stack_addr;
        wdata     = pc_in[7:0];
        we_raw    = (kind_q != K_RESET);
        s_dec_raw = 1'b1;
      end
      S_T4: begin
        addr      = stack_addr;
        wdata     = p_push;
        we_raw    = (kind_q != K_RESET);
        s_dec_raw = 1'b1;
      end
      S_T5: begin
        addr        = vec_q;
        p_write_raw = 1'b1;
      end
      S_T6: begin
        addr        = vec_q + 16'd1;
        pc_load_raw = 1'b1;
      end
      default: addr = pc_in;
    endcase
  end

  // Strobes only fire on a real step; reset suppresses any write that was
  // about to happen in the cycle it is asserted.
  assign strobe_ok = cpu_en & ~reset;

  assign busy      = reset | (state_q != S_IDLE);
  assign we        = we_raw & strobe_ok;
  assign s_dec     = s_dec_raw & strobe_ok;
  assign pc_load   = pc_load_raw & strobe_ok;
  assign pc_next   = {rd_data, lo_q};
  assign p_write   = (p_write_raw & strobe_ok) ? P_I_MASK : 8'h00;
  assign p_wd0     = p_write_raw ? P_I_MASK : 8'h00;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// tb_interrupt_sequencer
//
// Directed bench for interrupt_sequencer. A negedge monitor logs every
// enabled busy cycle (bus writes, strobes, vector addresses, PC load) and
// counts strobes seen on stalled or reset cycles. Each scenario pushes the
// hand-computed stack writes into exp_q and compares the log at the end.
// -----------------------------------------------------------------------------
module tb_interrupt_sequencer;

  logic        clk;
  logic        reset;
  logic        cpu_en;
  logic        nmi_n;
  logic        irq_n;
  logic        poll;
  logic        brk;
  logic [7:0]  p_in;
  logic [15:0] pc_in;
  logic [7:0]  s_in;
  logic [7:0]  rd_data;
  logic        busy;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        we;
  logic        s_dec;
  logic        pc_load;
  logic [15:0] pc_next;
  logic [7:0]  p_write;
  logic [7:0]  p_wd0;
  logic [2:0]  dbg_state;

  interrupt_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_en    (cpu_en),
    .nmi_n     (nmi_n),
    .irq_n     (irq_n),
    .poll      (poll),
    .brk       (brk),
    .p_in      (p_in),
    .pc_in     (pc_in),
    .s_in      (s_in),
    .rd_data   (rd_data),
    .busy      (busy),
    .addr      (addr),
    .wdata     (wdata),
    .we        (we),
    .s_dec     (s_dec),
    .pc_load   (pc_load),
    .pc_next   (pc_next),
    .p_write   (p_write),
    .p_wd0     (p_wd0),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Memory model: vectors only, everything else reads as NOP
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    case (a)
      16'hFFFA: mem_rd = 8'h00;
      16'hFFFB: mem_rd = 8'hA0;
      16'hFFFC: mem_rd = 8'h00;
      16'hFFFD: mem_rd = 8'h80;
      16'hFFFE: mem_rd = 8'h00;
      16'hFFFF: mem_rd = 8'h90;
      default:  mem_rd = 8'hEA;
    endcase
  endfunction

  assign rd_data = mem_rd(addr);

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [23:0] exp_q[$];
  logic [23:0] wr_q[$];
  logic [34:0] trace_q[$];
  logic [34:0] irq_trace[$];
  int          busy_cnt;
  int          sdec_cnt;
  int          pw_cnt;
  int          pcl_cnt;
  int          bad_cnt;
  logic [7:0]  last_pw;
  logic [7:0]  last_pwd;
  logic [15:0] last_pc_next;
  logic [15:0] vec_lo_addr;
  logic [15:0] vec_hi_addr;
  int          n_checks;
  int          n_pass;

  always @(negedge clk) begin
    if (reset || !cpu_en) begin
      if (we || s_dec || pc_load || (p_write != 8'h00)) bad_cnt++;
    end else if (busy) begin
      busy_cnt++;
      trace_q.push_back({addr, wdata, we, s_dec, pc_load, p_write});
      if (we) wr_q.push_back({addr, wdata});
      if (s_dec) sdec_cnt++;
      if (p_write != 8'h00) begin
        pw_cnt++;
        last_pw     = p_write;
        last_pwd    = p_wd0;
        vec_lo_addr = addr;
      end
      if (pc_load) begin
        pcl_cnt++;
        last_pc_next = pc_next;
        vec_hi_addr  = addr;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver / checking tasks
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    exp_q.delete();
    wr_q.delete();
    trace_q.delete();
    busy_cnt     = 0;
    sdec_cnt     = 0;
    pw_cnt       = 0;
    pcl_cnt      = 0;
    bad_cnt      = 0;
    last_pw      = 8'h00;
    last_pwd     = 8'h00;
    last_pc_next = 16'h0000;
    vec_lo_addr  = 16'h0000;
    vec_hi_addr  = 16'h0000;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && busy; i++) step();
    check(tag, busy, 1'b0);
  endtask

  task automatic check_seq(input int eb, input int es, input logic [15:0] ev,
                           input logic [15:0] epc);
    check("busy_cycles", busy_cnt, eb);
    check("s_dec_pulses", sdec_cnt, es);
    check("p_write_pulses", pw_cnt, 1);
    check("p_write_val", last_pw, 8'h04);
    check("p_wd0_val", last_pwd, 8'h04);
    check("vec_lo_addr", vec_lo_addr, ev);
    check("vec_hi_addr", vec_hi_addr, ev + 16'd1);
    check("pc_load_pulses", pcl_cnt, 1);
    check("pc_next", last_pc_next, epc);
    check("stall_strobes", bad_cnt, 0);
    check("write_count", wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < wr_q.size()) check("write_data", wr_q[i], exp_q[i]);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    cpu_en   = 1'b1;
    nmi_n    = 1'b1;
    irq_n    = 1'b1;
    poll     = 1'b0;
    brk      = 1'b0;
    p_in     = 8'h20;
    pc_in    = 16'h0000;
    s_in     = 8'hFD;
    clear_log();

    // Reset state
    step(); step(); step();
    check("rst_busy", busy, 1'b1);
    check("rst_we", we, 1'b0);
    check("rst_s_dec", s_dec, 1'b0);
    check("rst_pc_load", pc_load, 1'b0);
    check("rst_p_write", p_write, 8'h00);
    check("rst_state", dbg_state, 3'd1);

    // Power-on entry through RST_VEC
    clear_log();
    reset = 1'b0;
    wait_idle("rst_done");
    check_seq(7, 3, 16'hFFFC, 16'h8000);

    // IRQ
    clear_log();
    p_in  = 8'h20;
    pc_in = 16'h1234;
    s_in  = 8'hFF;
    irq_n = 1'b0;
    poll  = 1'b1;
    step();
    poll  = 1'b0;
    irq_n = 1'b1;
    check("irq_start", busy, 1'b1);
    exp_q.push_back(24'h01FF12);
    exp_q.push_back(24'h01FF34);
    exp_q.push_back(24'h01FF20);
    wait_idle("irq_done");
    check_seq(7, 3, 16'hFFFE, 16'h9000);
    irq_trace = trace_q;

    // IRQ masked by I
    p_in  = 8'h24;
    irq_n = 1'b0;
    poll  = 1'b1;
    step();
    check("irq_masked_busy", busy, 1'b0);
    check("irq_masked_state", dbg_state, 3'd0);
    poll  = 1'b0;
    irq_n = 1'b1;
    p_in  = 8'h20;

    // IRQ released before poll is not remembered
    irq_n = 1'b0;
    step();
    irq_n = 1'b1;
    poll  = 1'b1;
    step();
    check("irq_unlatched", busy, 1'b0);
    poll  = 1'b0;

    // BRK
    clear_log();
    pc_in = 16'h4567;
    s_in  = 8'hF0;
    brk   = 1'b1;
    poll  = 1'b1;
    step();
    brk   = 1'b0;
    poll  = 1'b0;
    exp_q.push_back(24'h01F045);
    exp_q.push_back(24'h01F067);
    exp_q.push_back(24'h01F030);
    wait_idle("brk_done");
    check_seq(7, 3, 16'hFFFE, 16'h9000);

    // BRK hijacked by an NMI edge during T2
    clear_log();
    brk  = 1'b1;
    poll = 1'b1;
    step();
    brk  = 1'b0;
    poll = 1'b0;
    step();
    step();
    check("hijack_t2", dbg_state, 3'd3);
    nmi_n = 1'b0;
    exp_q.push_back(24'h01F045);
    exp_q.push_back(24'h01F067);
    exp_q.push_back(24'h01F030);
    wait_idle("hijack_done");
    check_seq(7, 3, 16'hFFFA, 16'hA000);
    nmi_n = 1'b1;
    step();
    poll = 1'b1;
    step();
    check("nmi_cleared", busy, 1'b0);
    poll = 1'b0;

    // IRQ with cpu_en toggling every clock
    clear_log();
    p_in  = 8'h20;
    pc_in = 16'h1234;
    s_in  = 8'hFF;
    irq_n = 1'b0;
    poll  = 1'b1;
    step();
    poll  = 1'b0;
    irq_n = 1'b1;
    for (int i = 0; i < 40 && busy; i++) begin
      cpu_en = ~cpu_en;
      step();
    end
    cpu_en = 1'b1;
    check("tog_done", busy, 1'b0);
    check("tog_steps", busy_cnt, 7);
    check("tog_stall_strobes", bad_cnt, 0);
    check("tog_pc_next", last_pc_next, 16'h9000);
    check("tog_trace_len", trace_q.size(), irq_trace.size());
    for (int i = 0; i < irq_trace.size(); i++)
      if (i < trace_q.size()) check("tog_trace", trace_q[i], irq_trace[i]);

    // Reset during T3 of an NMI
    clear_log();
    pc_in = 16'hABCD;
    s_in  = 8'hFD;
    nmi_n = 1'b0;
    step();
    poll  = 1'b1;
    step();
    poll  = 1'b0;
    nmi_n = 1'b1;
    step();
    nmi_n = 1'b0;
    step();
    step();
    check("nmi_t3", dbg_state, 3'd4);
    reset = 1'b1;
    nmi_n = 1'b1;
    step();
    check("abort_state", dbg_state, 3'd1);
    check("abort_busy", busy, 1'b1);
    reset = 1'b0;
    exp_q.push_back(24'h01FDAB);
    wait_idle("abort_done");
    check_seq(10, 4, 16'hFFFC, 16'h8000);
    poll = 1'b1;
    step();
    check("nmi_lost", busy, 1'b0);
    poll = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
